// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus
// for the bit-serial subtractor. Building with SERSUB_OVF_EN adds the
// signed-overflow flag ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bor;
`ifdef SERSUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, bor, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bor, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bor);
  modport slave  (input start, a, b, output busy, done, diff, bor);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock.
// Each bit goes through two cascaded half-subtractors plus a registered
// borrow. The result is published on diff/bor with a one-cycle done pulse.
// The optional macro SERSUB_OVF_EN adds the two's-complement overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             finish;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             borrow;

  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bor_q;

  logic             hs1_d;
  logic             hs1_b;
  logic             hs2_b;
  logic             d_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] res_cat;

`ifdef SERSUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
  logic             ovf_q;
`endif

  // State register; reset always returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and the load/step/finish strobes for the datapath.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One full-subtractor step built from two half-subtractors on the current LSBs.
  always_comb begin
    hs1_d       = a_sr[0] ^ b_sr[0];
    hs1_b       = ~a_sr[0] & b_sr[0];
    d_bit       = hs1_d ^ borrow;
    hs2_b       = ~hs1_d & borrow;
    borrow_next = hs1_b | hs2_b;
    res_cat     = {d_bit, res_sr};
  end

  // Operand/result shifting, bit counter, borrow flop and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bor_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (load) begin
        a_sr   <= bus.a;
        b_sr   <= bus.b;
        res_sr <= '0;
        cnt    <= '0;
        borrow <= 1'b0;
`ifdef SERSUB_OVF_EN
        a_msb  <= bus.a[WIDTH-1];
        b_msb  <= bus.b[WIDTH-1];
`endif
      end
      if (step) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= res_cat[WIDTH-1:1];
        cnt    <= cnt + 1'b1;
        borrow <= borrow_next;
      end
      if (finish) begin
        diff_q <= res_cat;
        bor_q  <= borrow_next;
        done_q <= 1'b1;
`ifdef SERSUB_OVF_EN
        ovf_q  <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bor  = bor_q;
`ifdef SERSUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
